// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: T-state ring indices, the HALT mode
// encoding and the default halt opcode.
package fetch_sequencer_pkg;
  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;

  localparam logic [3:0] HLT_OPCODE_DEFAULT = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } mode_e;
endpackage

// File: rtl/fetch_sequencer_t_state_ring.sv
// One-hot T-state ring: resets to T1, rotates on advance, freezes while hold is high.
module t_state_ring #(
  parameter int NUM_T = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             hold,
  output logic [NUM_T-1:0] ring
);
  always_ff @(posedge clk) begin
    if (rst)
      ring <= NUM_T'(1);
    else if (advance && !hold)
      ring <= {ring[NUM_T-2:0], ring[NUM_T-1]};
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: T1 loads MAR, T2 bumps PC, T3 loads IR, T4.. execute.
// HALT on HLT_OPCODE exists only when FETCH_SEQUENCER_HLT_DETECT_EN is defined.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int         NUM_T      = 6,
  parameter logic [3:0] HLT_OPCODE = HLT_OPCODE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [3:0]       pc_count,
  input  logic [7:0]       mem_data,
  output logic             pc_enable,
  output logic [3:0]       mar_addr,
  output logic [7:0]       ir,
  output logic [3:0]       opcode,
  output logic [3:0]       operand,
  output logic [NUM_T-1:0] t_state,
  output logic             instr_valid,
  output logic             halted
);
`ifdef FETCH_SEQUENCER_HLT_DETECT_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  logic [NUM_T-1:0] ring;
  mode_e            mode;
  logic             advance;
  logic             hold;
  logic             hlt_hit;

  // Only the T1 wait is gated by run; every other T-state always advances.
  assign advance = run || !ring[T1_IDX];
  assign hlt_hit = HLT_EN && (mode == ST_RUN) && ring[T4_IDX] && (ir[7:4] == HLT_OPCODE);
  assign hold    = (mode == ST_HALT) || hlt_hit;

  t_state_ring #(.NUM_T(NUM_T)) u_ring (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .hold    (hold),
    .ring    (ring)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= ST_RUN;
      mar_addr    <= 4'h0;
      ir          <= 8'h00;
      pc_enable   <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      pc_enable   <= 1'b0;
      instr_valid <= 1'b0;
      if (!hold) begin
        // Strobes are registered on entry, so they line up with T2 and T4.
        if (ring[T1_IDX] && run) begin
          mar_addr  <= pc_count;
          pc_enable <= 1'b1;
        end
        if (ring[T3_IDX]) begin
          ir          <= mem_data;
          instr_valid <= 1'b1;
        end
      end
      if (hlt_hit)
        mode <= ST_HALT;
    end
  end

  assign opcode  = ir[7:4];
  assign operand = ir[3:0];
  assign t_state = (mode == ST_HALT) ? '0 : ring;

`ifdef FETCH_SEQUENCER_HLT_DETECT_EN
  assign halted = (mode == ST_HALT);
`else
  assign halted = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a T-state model checks every cycle, and a
// queue of expected fetches is checked on each instr_valid pulse.
module tb_fetch_sequencer;
  localparam int NUM_T = 6;
`ifdef FETCH_SEQUENCER_HLT_DETECT_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             run;
  logic [3:0]       pc;
  logic [7:0]       mem_data;
  logic             pc_enable;
  logic [3:0]       mar_addr;
  logic [7:0]       ir;
  logic [3:0]       opcode;
  logic [3:0]       operand;
  logic [NUM_T-1:0] t_state;
  logic             instr_valid;
  logic             halted;

  logic [7:0] mem [16];

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.NUM_T(NUM_T), .HLT_OPCODE(4'hF)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pc_count    (pc),
    .mem_data    (mem_data),
    .pc_enable   (pc_enable),
    .mar_addr    (mar_addr),
    .ir          (ir),
    .opcode      (opcode),
    .operand     (operand),
    .t_state     (t_state),
    .instr_valid (instr_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mar_addr];

  // Program counter wired back to the sequencer.
  always @(posedge clk) begin
    if (rst) pc <= 4'h0;
    else if (pc_enable) pc <= pc + 4'h1;
  end

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: phase 0..NUM_T-1, fetch number since reset, halted flag.
  int         ph = 0;
  int         nf = 0;
  bit         mh = 1'b0;
  bit         ok = 1'b0;
  logic [7:0] m_ir = 8'h00;

  always @(posedge clk) begin
    if (rst) begin
      ph = 0; nf = 0; mh = 1'b0; ok = 1'b1; m_ir = 8'h00;
    end else if (ok && !mh && !(ph == 0 && !run)) begin
      if (ph == 2) begin
        m_ir = mem[nf % 16];
        nf++;
      end
      if (ph == 3 && HLT_EN && m_ir[7:4] == 4'hF) mh = 1'b1;
      ph = (ph + 1) % NUM_T;
    end
  end

  // Monitor: per-cycle timing against the model, fetch contents against the queue.
  always @(negedge clk) begin
    if (ok) begin
      logic [NUM_T-1:0] et;
      et = mh ? '0 : NUM_T'(1) << ph;
      chk("t_state", int'(t_state), int'(et));
      chk("pc_enable", int'(pc_enable), int'(!mh && ph == 1));
      chk("instr_valid", int'(instr_valid), int'(!mh && ph == 3));
      chk("halted", int'(halted), int'(mh));
      if (instr_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_fetch", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("mar_addr", int'(mar_addr), int'(e.a));
          chk("ir", int'(ir), int'(e.d));
          chk("opcode", int'(opcode), int'(e.d[7:4]));
          chk("operand", int'(operand), int'(e.d[3:0]));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_phase(int p);
    int c = 0;
    while (ph != p && c < 100) begin
      tick();
      c++;
    end
    if (ph != p) chk("wait_phase_timeout", ph, p);
  endtask

  task automatic drain();
    int c = 0;
    while (q.size() > 0 && c < 3000) begin
      run = ($urandom_range(0, 3) != 0);
      tick();
      c++;
    end
    run = 1'b0;
    chk("drain_left", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'($urandom);
      if (HLT_EN && mem[i][7:4] == 4'hF) mem[i][7:4] = 4'hE;
    end
    mem[3] = 8'h2A;
    if (!HLT_EN) mem[5] = 8'hF7;

    repeat (2) tick();
    chk("rst_t_state", int'(t_state), 1);
    chk("rst_mar", int'(mar_addr), 0);
    chk("rst_ir", int'(ir), 0);
    chk("rst_pc_enable", int'(pc_enable), 0);

    // 17 fetches with the PC wired back: addresses 0..F then wrap to 0.
    for (int k = 0; k < 17; k++) q.push_back('{a: 4'(k % 16), d: mem[k % 16]});
    rst = 1'b0;
    drain();

    // Idle in T1 with run low, then one more fetch.
    wait_phase(0);
    repeat (5) tick();
    chk("idle_t_state", int'(t_state), 1);
    chk("idle_pc_enable", int'(pc_enable), 0);
    q.push_back('{a: 4'(nf % 16), d: mem[nf % 16]});
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("resume_t_state", int'(t_state), 2);
    drain();

    // Reset in the middle of T3 aborts the fetch with no instr_valid pulse.
    wait_phase(0);
    run = 1'b1;
    wait_phase(2);
    rst = 1'b1;
    run = 1'b0;
    tick();
    chk("t3rst_t_state", int'(t_state), 1);
    chk("t3rst_ir", int'(ir), 0);
    chk("t3rst_mar", int'(mar_addr), 0);
    rst = 1'b0;
    repeat (8) tick();

    if (HLT_EN) begin
      rst = 1'b1;
      mem[0] = 8'hF0;
      tick();
      q.push_back('{a: 4'h0, d: 8'hF0});
      rst = 1'b0;
      run = 1'b1;
      repeat (25) tick();
      chk("halt_halted", int'(halted), 1);
      chk("halt_queue", q.size(), 0);
      rst = 1'b1;
      tick();
      chk("halt_cleared", int'(halted), 0);
      rst = 1'b0;
      run = 1'b0;
      repeat (3) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter NUM_T, default 6, number of T-states per instruction cycle (legal range 4..8).
REQ-002 SHALL have parameter HLT_OPCODE, default 4'hF, the opcode value that halts the machine.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port run  input  1  when low, the sequencer holds in T1 and starts no fetch.
REQ-006 SHALL have port pc_count  input  4  current value of the program counter.
REQ-007 SHALL have port mem_data  input  8  combinational program-memory read data for mar_addr.
REQ-008 SHALL have port pc_enable  output  1  program-counter increment strobe.
REQ-009 SHALL have port mar_addr  output  4  memory address register, drives program memory.
REQ-010 SHALL have port ir  output  8  instruction register.
REQ-011 SHALL have port opcode  output  4  equal to ir[7:4].
REQ-012 SHALL have port operand  output  4  equal to ir[3:0].
REQ-013 SHALL have port t_state  output  NUM_T  one-hot current T-state; bit 0 is T1.
REQ-014 SHALL have port instr_valid  output  1  one-cycle pulse, the cycle after IR is loaded.
REQ-015 SHALL have port halted  output  1  high while in HALT.

Function
REQ-016 SHALL be a Moore FSM with states T1..T<NUM_T> and HALT; outputs decode from registered state.
REQ-017 T1: mar_addr SHALL load pc_count at the clock edge that leaves T1.
REQ-018 T1 SHALL be left only when run=1; with run=0 the state, mar_addr and ir SHALL hold.
REQ-019 T2: pc_enable SHALL be 1 for exactly this one cycle; it SHALL be 0 in every other state.
REQ-020 T3: ir SHALL load mem_data at the clock edge that leaves T3.
REQ-021 instr_valid SHALL be 1 for exactly the cycle in T4.
REQ-022 T4..T<NUM_T> are execute slots; the block SHALL only advance through them, updating no register.
REQ-023 After T<NUM_T>, the FSM SHALL wrap to T1, giving one fetch every NUM_T cycles when run=1.
REQ-024 In T4, if opcode==HLT_OPCODE, the next state SHALL be HALT.
REQ-025 HALT SHALL hold until rst; in HALT, t_state=0, pc_enable=0, and ir/mar_addr hold.
REQ-026 run deasserted outside T1 SHALL NOT stall; the current instruction cycle completes.
REQ-027 pc_count wrap 4'hF->4'h0 SHALL be fetched like any address, with no special handling.

Reset
REQ-028 rst=1 at a clock edge SHALL force the following, from any state including mid-fetch and HALT: state=T1, mar_addr=0, ir=0, instr_valid=0, pc_enable=0, halted=0.
REQ-029 rst SHALL take priority over run and over HALT entry in the same cycle.

Configuration
REQ-030 With macro FETCH_SEQUENCER_HLT_DETECT_EN defined, REQ-024/025 SHALL apply.
REQ-031 Without FETCH_SEQUENCER_HLT_DETECT_EN, HALT SHALL not exist, halted SHALL be tied 0, and HLT_OPCODE SHALL be treated as an ordinary opcode.

Structure
REQ-032 The shared package SHALL hold the T-state index constants, the HALT encoding and the default HLT_OPCODE.
REQ-033 The one-hot T-state ring SHALL be a sub-module named t_state_ring, with inputs clk, rst, advance and hold and a one-hot output; the FSM in fetch_sequencer drives it.

Verification
REQ-034 rst=1 for 2 cycles, then 0, run=1 -> t_state=000001, mar_addr=0, ir=0, pc_enable=0 during reset; then t_state advances one-hot every cycle.
REQ-035 pc_count=4'h3, mem_data=8'h2A, run=1 -> mar_addr=3 after T1; pc_enable=1 only in T2; ir=8'h2A, opcode=2, operand=A; instr_valid=1 in T4 only.
REQ-036 run=0 in T1 for 5 cycles -> t_state stays 000001, pc_enable=0; run=1 -> T2 on the next edge.
REQ-037 With HLT_DETECT_EN defined, mem_data=8'hF0 -> halted=1 from the cycle after T4; pc_enable stays 0 for 20 cycles; rst clears halted.
REQ-038 rst asserted in T3 -> next cycle t_state=T1, ir=0, no instr_valid pulse.
REQ-039 Loop with the program counter connected for 17 fetches -> mar_addr sequence 0..F,0; exactly one pc_enable per NUM_T cycles.
